// File: rtl/vga_pkg.sv
// Shared 640x480@60Hz timing constants and pixel-interface widths.
// img_generator imports this package too.
package vga_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned COORD_W     = 12;
  localparam int unsigned COLOR_DEPTH = 4;
  localparam int unsigned COLOR_W     = 3;

  // Bit positions inside the 3-bit colour word
  localparam int unsigned R_BIT = 2;
  localparam int unsigned G_BIT = 1;
  localparam int unsigned B_BIT = 0;

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-N raster axis counter with enable; wrap_c_o flags the enabled N-1 -> 0 step.
module vga_axis_counter #(
  parameter int unsigned N = 800,
  parameter int unsigned W = 12
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         wrap_c_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         at_max_c;

  always_comb begin
    count_d  = count_q;
    at_max_c = (count_q == W'(N - 1));
    if (en_i) begin
      count_d = at_max_c ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign wrap_c_o = en_i & at_max_c;

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster timing: presents (x,y) to the pixel source, registers blanked colour and
// syncs so every VGA output lags the presented coordinate by exactly one clock.
module vga_timing_controller
  import vga_pkg::*;
#(
  parameter int unsigned H_VIS = H_VISIBLE,
  parameter int unsigned H_FP  = H_FRONT,
  parameter int unsigned H_SW  = H_SYNC,
  parameter int unsigned H_BP  = H_BACK,
  parameter int unsigned V_VIS = V_VISIBLE,
  parameter int unsigned V_FP  = V_FRONT,
  parameter int unsigned V_SW  = V_SYNC,
  parameter int unsigned V_BP  = V_BACK
) (
  input  logic                   CLOCK_25,
  input  logic                   RESET_N,
  output logic [COORD_W-1:0]     x,
  output logic [COORD_W-1:0]     y,
  input  logic [COLOR_W-1:0]     color,
  output logic [COLOR_DEPTH-1:0] VGA_R,
  output logic [COLOR_DEPTH-1:0] VGA_G,
  output logic [COLOR_DEPTH-1:0] VGA_B,
  output logic                   VGA_HS,
  output logic                   VGA_VS,
  output logic                   video_active,
  output logic                   frame_start
);

  localparam int unsigned H_TOT    = H_VIS + H_FP + H_SW + H_BP;
  localparam int unsigned V_TOT    = V_VIS + V_FP + V_SW + V_BP;
  localparam int unsigned HS_START = H_VIS + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SW;
  localparam int unsigned VS_START = V_VIS + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SW;

  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic               h_wrap_c;
  logic               v_wrap_c;

  vga_axis_counter #(.N(H_TOT), .W(COORD_W)) u_h_cnt (
    .clk_i    (CLOCK_25),
    .rst_ni   (RESET_N),
    .en_i     (1'b1),
    .count_o  (h_cnt),
    .wrap_c_o (h_wrap_c)
  );

  vga_axis_counter #(.N(V_TOT), .W(COORD_W)) u_v_cnt (
    .clk_i    (CLOCK_25),
    .rst_ni   (RESET_N),
    .en_i     (h_wrap_c),
    .count_o  (v_cnt),
    .wrap_c_o (v_wrap_c)
  );

  assign x = h_cnt;
  assign y = v_cnt;

  logic                   vis_c;
  logic [COLOR_DEPTH-1:0] r_d, g_d, b_d;
  logic [COLOR_DEPTH-1:0] r_q, g_q, b_q;
  logic                   hs_d, vs_d, hs_q, vs_q;
  logic                   act_q, fs_q;

  // Decode the presented (h,v); the syncs use the same coordinate as the pixel.
  always_comb begin
    vis_c = (h_cnt < COORD_W'(H_VIS)) && (v_cnt < COORD_W'(V_VIS));
    hs_d  = !((h_cnt >= COORD_W'(HS_START)) && (h_cnt < COORD_W'(HS_END)));
    vs_d  = !((v_cnt >= COORD_W'(VS_START)) && (v_cnt < COORD_W'(VS_END)));
    r_d   = {COLOR_DEPTH{color[R_BIT] & vis_c}};
    g_d   = {COLOR_DEPTH{color[G_BIT] & vis_c}};
    b_d   = {COLOR_DEPTH{color[B_BIT] & vis_c}};
  end

  // v_wrap_c marks the last clock of a frame, so frame_start rises as (0,0) is presented.
  always_ff @(posedge CLOCK_25) begin
    if (!RESET_N) begin
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      act_q <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      r_q   <= r_d;
      g_q   <= g_d;
      b_q   <= b_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      act_q <= vis_c;
      fs_q  <= v_wrap_c;
    end
  end

  assign VGA_R        = r_q;
  assign VGA_G        = g_q;
  assign VGA_B        = b_q;
  assign VGA_HS       = hs_q;
  assign VGA_VS       = vs_q;
  assign video_active = act_q;
  assign frame_start  = fs_q;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench: full-size instance for line timing, a scaled instance for frame timing.
module tb_vga_timing_controller;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  color;

  logic [11:0] x, y;
  logic [3:0]  r, g, b;
  logic        hs, vs, va, fs;

  logic [11:0] xs, ys;
  logic [3:0]  rs, gs, bs;
  logic        hss, vss, vas, fss;

  int checks = 0;
  int errors = 0;

  always #20 clk = ~clk;

  vga_timing_controller dut (
    .CLOCK_25(clk), .RESET_N(rst_n), .x(x), .y(y), .color(color),
    .VGA_R(r), .VGA_G(g), .VGA_B(b), .VGA_HS(hs), .VGA_VS(vs),
    .video_active(va), .frame_start(fs)
  );

  // Scaled raster: 24 clocks/line (16 visible, sync 18..21), 17 lines/frame (10 visible, vsync 12..13)
  vga_timing_controller #(
    .H_VIS(16), .H_FP(2), .H_SW(4), .H_BP(2),
    .V_VIS(10), .V_FP(2), .V_SW(2), .V_BP(3)
  ) dut_s (
    .CLOCK_25(clk), .RESET_N(rst_n), .x(xs), .y(ys), .color(color),
    .VGA_R(rs), .VGA_G(gs), .VGA_B(bs), .VGA_HS(hss), .VGA_VS(vss),
    .video_active(vas), .frame_start(fss)
  );

  // Returns on the falling edge where (0,0) is presented just after release.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [39:0] want;
    logic [39:0] got;
    @(negedge clk);
    rst_n = 1'b0;
    color = 3'b111;
    repeat (3) @(negedge clk);
    want = {24'd0, 2'b11, 12'd0, 2'b00};
    got  = {x, y, hs, vs, r, g, b, va, fs};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_state got %h want %h", got, want);
    end
    got = {xs, ys, hss, vss, rs, gs, bs, vas, fss};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_state_small got %h want %h", got, want);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (x !== 12'(i) || y !== 12'd0 || fs !== 1'b0) begin
        errors++;
        $display("FAIL release_count got x=%0d y=%0d fs=%b want x=%0d y=0 fs=0", x, y, fs, i);
      end
      if (i == 1) begin
        checks++;
        if ({r, g, b, va} !== {12'hFFF, 1'b1}) begin
          errors++;
          $display("FAIL first_pixel got rgb=%h va=%b want rgb=fff va=1", {r, g, b}, va);
        end
      end
    end
  endtask

  task automatic test_hsync();
    int   px, nf, fall0, fall1, rise0, bad, badpos;
    logic hs_last, exp_hs;
    do_reset();
    color = 3'b000;
    px = 0; nf = 0; fall0 = -1; fall1 = -1; rise0 = -1; bad = 0; badpos = 0;
    hs_last = 1'b1;
    for (int c = 1; c <= 1700; c++) begin
      @(negedge clk);
      exp_hs = !(px >= 656 && px < 752);
      if (hs !== exp_hs) bad++;
      if (hs_last && !hs) begin
        if (px != 656) badpos++;
        if (nf == 0) fall0 = c;
        else if (nf == 1) fall1 = c;
        nf++;
      end
      if (!hs_last && hs && rise0 < 0) rise0 = c;
      hs_last = hs;
      px = int'(x);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hs_shape got %0d bad cycles want 0", bad); end
    checks++;
    if (nf != 2) begin errors++; $display("FAIL hs_fall_count got %0d want 2", nf); end
    checks++;
    if (fall0 != 657) begin errors++; $display("FAIL hs_first_fall got cycle %0d want 657", fall0); end
    checks++;
    if (fall1 - fall0 != 800) begin errors++; $display("FAIL hs_period got %0d want 800", fall1 - fall0); end
    checks++;
    if (rise0 - fall0 != 96) begin errors++; $display("FAIL hs_width got %0d want 96", rise0 - fall0); end
    checks++;
    if (badpos != 0) begin errors++; $display("FAIL hs_fall_pos got %0d misplaced want 0", badpos); end
  endtask

  task automatic test_blanking();
    int          px, py, bad;
    logic        exp_vis;
    logic [11:0] exp_rgb;
    do_reset();
    color = 3'b111;
    px = 0; py = 0; bad = 0;
    for (int c = 1; c <= 1700; c++) begin
      @(negedge clk);
      exp_vis = (px < 640) && (py < 480);
      exp_rgb = exp_vis ? 12'hFFF : 12'h000;
      if ({r, g, b} !== exp_rgb || va !== exp_vis) bad++;
      if (px == 639 || px == 640) begin
        checks++;
        if ({r, g, b} !== exp_rgb) begin
          errors++;
          $display("FAIL hblank_edge x=%0d got %h want %h", px, {r, g, b}, exp_rgb);
        end
      end
      px = int'(x);
      py = int'(y);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL blank_shape got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_mapping();
    int n;
    do_reset();
    color = 3'b000;
    n = 0;
    while (!(x == 12'd10 && y == 12'd10) && n < 9000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(x == 12'd10 && y == 12'd10)) begin
      errors++;
      $display("FAIL map_reach got x=%0d y=%0d want 10,10 (timeout)", x, y);
    end
    color = 3'b100;
    @(negedge clk);
    checks++;
    if ({r, g, b} !== 12'hF00) begin errors++; $display("FAIL map_red got %h want f00", {r, g, b}); end
    color = 3'b001;
    @(negedge clk);
    checks++;
    if ({r, g, b} !== 12'h00F) begin errors++; $display("FAIL map_blue got %h want 00f", {r, g, b}); end
    color = 3'b010;
    @(negedge clk);
    checks++;
    if ({r, g, b} !== 12'h0F0) begin errors++; $display("FAIL map_green got %h want 0f0", {r, g, b}); end
    color = 3'b000;
    @(negedge clk);
    checks++;
    if ({r, g, b, va} !== {12'h000, 1'b1}) begin
      errors++;
      $display("FAIL map_black got rgb=%h va=%b want 000 1", {r, g, b}, va);
    end
  endtask

  task automatic test_midframe_reset();
    int          n, px, fall;
    logic [39:0] got;
    logic        hs_last;
    do_reset();
    color = 3'b111;
    n = 0;
    while (!(x == 12'd300 && y == 12'd2) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(x == 12'd300 && y == 12'd2)) begin
      errors++;
      $display("FAIL mid_reach got x=%0d y=%0d want 300,2 (timeout)", x, y);
    end
    rst_n = 1'b0;
    @(negedge clk);
    got = {x, y, hs, vs, r, g, b, va, fs};
    checks++;
    if (got !== {24'd0, 2'b11, 12'd0, 2'b00}) begin
      errors++;
      $display("FAIL mid_reset_state got %h want %h", got, {24'd0, 2'b11, 12'd0, 2'b00});
    end
    @(negedge clk);
    rst_n = 1'b1;
    px = 0; fall = -1; hs_last = 1'b1;
    for (int c = 1; c <= 1000 && fall < 0; c++) begin
      @(negedge clk);
      if (hs_last && !hs) begin
        fall = c;
        checks++;
        if (px != 656) begin errors++; $display("FAIL mid_fall_pos got x=%0d want 656", px); end
      end
      hs_last = hs;
      px = int'(x);
    end
    checks++;
    if (fall != 657) begin errors++; $display("FAIL mid_hs_fall got cycle %0d want 657", fall); end
  endtask

  task automatic test_vsync_frame();
    int          px, py, bad, badpix, badfs, vfall, vrise, nfs, fs0, fs1;
    logic        vs_last, exp_vs, exp_vis;
    do_reset();
    color = 3'b111;
    px = 0; py = 0; bad = 0; badpix = 0; badfs = 0;
    vfall = -1; vrise = -1; nfs = 0; fs0 = -1; fs1 = -1;
    vs_last = 1'b1;
    for (int c = 1; c <= 900; c++) begin
      @(negedge clk);
      exp_vs  = !(py >= 12 && py < 14);
      exp_vis = (px < 16) && (py < 10);
      if (vss !== exp_vs) bad++;
      if ({rs, gs, bs, vas} !== {exp_vis ? 12'hFFF : 12'h000, exp_vis}) badpix++;
      if (px == 0 && py == 10) begin
        checks++;
        if ({rs, gs, bs} !== 12'h000) begin
          errors++;
          $display("FAIL vblank_edge got %h want 000", {rs, gs, bs});
        end
      end
      if (vs_last && !vss && vfall < 0) begin
        vfall = c;
        checks++;
        if (px != 0 || py != 12) begin
          errors++;
          $display("FAIL vs_fall_pos got x=%0d y=%0d want 0,12", px, py);
        end
      end
      if (!vs_last && vss && vrise < 0) vrise = c;
      vs_last = vss;
      if (fss) begin
        if (!(xs == 12'd0 && ys == 12'd0)) badfs++;
        if (nfs == 0) fs0 = c;
        else if (nfs == 1) fs1 = c;
        nfs++;
      end
      px = int'(xs);
      py = int'(ys);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL vs_shape got %0d bad cycles want 0", bad); end
    checks++;
    if (vfall != 289) begin errors++; $display("FAIL vs_first_fall got cycle %0d want 289", vfall); end
    checks++;
    if (vrise - vfall != 48) begin errors++; $display("FAIL vs_width got %0d want 48", vrise - vfall); end
    checks++;
    if (badpix != 0) begin errors++; $display("FAIL frame_pixels got %0d bad cycles want 0", badpix); end
    checks++;
    if (nfs != 2 || badfs != 0) begin
      errors++;
      $display("FAIL fs_count got %0d pulses (%0d misplaced) want 2 (0)", nfs, badfs);
    end
    checks++;
    if (fs0 != 408 || fs1 - fs0 != 408) begin
      errors++;
      $display("FAIL fs_period got first=%0d gap=%0d want 408 408", fs0, fs1 - fs0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    color = 3'b000;
    test_reset();
    test_hsync();
    test_blanking();
    test_mapping();
    test_midframe_reset();
    test_vsync_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
